mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Parametrised multi-cycle control unit for the MIPS multi-cycle CPU. It extends the fixed fetch/decode/execute controller in three ways: a variable-latency memory request/ready handshake, BNE/ADDI/J support, and a retired-instruction counter. It sits between the instruction register fields (opcode/funct), the ALU zero flag and the unified instruction/data memory. It drives every datapath select and write strobe directly, including the final PC enable.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- ALU_ADD, 4'b0000: ALUControl code for add.
- ALU_SUB, 4'b0001: ALUControl code for subtract.
- ALU_AND, 4'b0010: ALUControl code for and.
- ALU_OR, 4'b0011: ALUControl code for or.
- ALU_SLT, 4'b0100: ALUControl code for set-less-than.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Op  in  6  instruction[31:26] from IR.
- Funct  in  6  instruction[5:0] from IR.
- Zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemWrite  out  1  write strobe; meaningful only with mem_req.
- IRWrite  out  1  load IR.
- RegWrite  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUControl  out  4  ALU operation code.
- PCEn  out  1  PCWrite | (beq & Zero) | (bne & ~Zero).
- state  out  4  current state encoding.
- retired  out  CNT_W  count of completed instructions.
- trap  out  1  illegal instruction halt (see Configuration).

## Operation
- State encoding:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMRD
  - 4 MEMWB
  - 5 MEMWR
  - 6 EXEC
  - 7 ALUWB
  - 8 BRANCH
  - 9 ADDIEX
  - 10 ADDIWB
  - 11 JUMP
  - 12 TRAP
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ALU_ADD, PCSrc=00.
  - IRWrite and PCEn asserted only in the cycle mem_ready=1; that cycle advances to DECODE, otherwise the FSM stays in FETCH.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALU_ADD (branch target into ALUOut).
  - Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) or 000101 (bne) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - Any other Op, or R-type with Funct outside {100000, 100010, 100100, 100101, 101010} -> illegal.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_ADD; next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1; wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1; next state FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1; wait for mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00; ALUControl from Funct: add->ADD, sub->SUB, and->AND, or->OR, slt->SLT. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0; next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_SUB, PCSrc=01; PCEn per the beq/bne rule; next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_ADD; next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0; next state FETCH.
- JUMP: PCSrc=10, PCEn=1; next state FETCH.
- retired increments by 1 on the completing cycle of MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB and JUMP. It wraps modulo 2^CNT_W.
- Unlisted outputs are 0 in each state.

## Timing
- Reset (RST_N low, asynchronous):
  - state=FETCH, retired=0, trap=0.
  - mem_req, IRWrite, PCEn, MemWrite and RegWrite are forced to 0 while RST_N is low.
- First fetch request: the first cycle after RST_N rises.
- Cycles per instruction with mem_ready tied high:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
- Each memory wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR. All outputs stay stable while waiting.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset mid-instruction aborts immediately to FETCH; retired is cleared.
- Simultaneous wrap and increment: retired goes from 2^CNT_W-1 to 0.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: an illegal instruction moves DECODE -> TRAP.
  - TRAP sets trap=1 and all strobes to 0, and holds until reset.
  - retired is not incremented.
- MC_ILLEGAL_TRAP_EN undefined: an illegal instruction moves DECODE -> FETCH as a NOP.
  - retired increments on that DECODE cycle.
  - trap is tied to 0 and state 12 is unreachable.

## Test plan
- Reset, mem_ready=1, lw (Op=100011) -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; retired=1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and mem_req=1 held for 4 cycles; FETCH follows the mem_ready cycle; instruction takes 7 cycles.
- bne with Zero=0 -> PCEn=1 in BRANCH with PCSrc=01; bne with Zero=1 -> PCEn=0; beq gives the mirrored result.
- R-type Funct=101010 -> ALUControl=ALU_SLT in EXEC; Funct=100010 -> ALU_SUB; RegDst=1 in ALUWB.
- Op=111111 with MC_ILLEGAL_TRAP_EN defined -> state=12, trap=1 held for 10 cycles; without the macro -> FETCH follows DECODE and retired increments.
- CNT_W=4: run 16 j instructions -> retired wraps to 0; assert RST_N low mid-MEMRD -> state=0, mem_req=0 during reset.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Memory request/ready handshake between the multi-cycle controller and the
// unified instruction/data memory.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_ready;
  logic IorD;
  logic MemWrite;

  modport master (output mem_req, output IorD, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input IorD, input MemWrite, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit with variable-latency memory and a retired counter.
// Define MC_ILLEGAL_TRAP_EN to halt in TRAP on illegal instructions instead of skipping them.
module mc_ctrl_fsm #(
  parameter int         CNT_W   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001,
  parameter logic [3:0] ALU_AND = 4'b0010,
  parameter logic [3:0] ALU_OR  = 4'b0011,
  parameter logic [3:0] ALU_SLT = 4'b0100
) (
  input  logic             CLK,
  input  logic             RST_N,
  mc_ctrl_fsm_if.master    mem_bus,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [3:0]       ALUControl,
  output logic             PCEn,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_ctl;
    logic       pc_write;
    logic       beq;
    logic       bne;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t          state_q;
  state_t          nxt;
  ctrl_t           ctrl_q;
  logic            retire;
  logic [CNT_W-1:0] retired_q;

  function automatic logic legal_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    logic [3:0] a;
    case (f)
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Outputs are registered, so they are derived from the state being entered.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op,
                                     input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch     = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_ctl   = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_ctl   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctl   = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = funct_alu(f);
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = ALU_SUB;
        c.pc_src    = 2'b01;
        c.beq       = (op == OP_BEQ);
        c.bne       = (op == OP_BNE);
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt    = state_q;
    retire = 1'b0;
    case (state_q)
      S_FETCH:  nxt = mem_bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW))
          nxt = S_MEMADR;
        else if ((Op == OP_RTYPE) && legal_funct(Funct))
          nxt = S_EXEC;
        else if ((Op == OP_BEQ) || (Op == OP_BNE))
          nxt = S_BRANCH;
        else if (Op == OP_ADDI)
          nxt = S_ADDIEX;
        else if (Op == OP_J)
          nxt = S_JUMP;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          nxt = S_TRAP;
`else
          nxt    = S_FETCH;
          retire = 1'b1;
`endif
        end
      end
      S_MEMADR: nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_MEMWR: begin
        nxt    = mem_bus.mem_ready ? S_FETCH : S_MEMWR;
        retire = mem_bus.mem_ready;
      end
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic trap_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_for(S_FETCH, 6'd0, 6'd0);
      retired_q <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q <= nxt;
      ctrl_q  <= ctrl_for(nxt, Op, Funct);
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
`ifdef MC_ILLEGAL_TRAP_EN
      trap_q  <= (nxt == S_TRAP);
`endif
    end
  end

  // Strobes are gated by RST_N so nothing fires while reset is held.
  assign mem_bus.mem_req  = ctrl_q.mem_req & RST_N;
  assign mem_bus.IorD     = ctrl_q.iord;
  assign mem_bus.MemWrite = ctrl_q.mem_write & RST_N;
  assign IRWrite    = ctrl_q.fetch & mem_bus.mem_ready & RST_N;
  assign RegWrite   = ctrl_q.reg_write & RST_N;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign PCSrc      = ctrl_q.pc_src;
  assign ALUControl = ctrl_q.alu_ctl;
  assign PCEn       = RST_N & (ctrl_q.pc_write |
                               (ctrl_q.fetch & mem_bus.mem_ready) |
                               (ctrl_q.beq & Zero) |
                               (ctrl_q.bne & ~Zero));
  assign state      = state_q;
  assign retired    = retired_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign trap       = trap_q;
`else
  assign trap       = 1'b0;
`endif

endmodule
